// File: rtl/divider_iterative_if.sv
// rtl/divider_iterative_if.sv - request/result bundle between execute stage and divider
interface divider_iterative_if;
   logic        startE;
   logic [1:0]  div_opcode;
   logic [31:0] operand1;
   logic [31:0] operand2;
   logic [31:0] result_divide;
   logic        done;
   logic        div_use;

   modport master (
      output startE, div_opcode, operand1, operand2,
      input  result_divide, done, div_use
   );

   modport slave (
      input  startE, div_opcode, operand1, operand2,
      output result_divide, done, div_use
   );
endinterface

// File: rtl/divider_iterative.sv
// rtl/divider_iterative.sv - radix-2 restoring divider for DIV/DIVU/REM/REMU, 33-cycle latency
module divider_iterative #(
   parameter logic [1:0] DIV  = 2'b00,
   parameter logic [1:0] DIVU = 2'b01,
   parameter logic [1:0] REM  = 2'b10,
   parameter logic [1:0] REMU = 2'b11
) (
   input  logic         clk,
   input  logic         rst,
   divider_iterative_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t      state, state_next;
   logic [1:0]  op;
   logic        sign_a, sign_b, special;
   logic [31:0] dividend, divisor, quot, rem;
   logic [4:0]  counter;
   logic [31:0] result_q;
   logic        done_q, busy_q;

   logic        start_signed, start_zero, start_ovf;
   logic        op_signed;
   logic [32:0] rem_shift, diff;
   logic [31:0] quot_fix, rem_fix, result_fix;

   assign bus.result_divide = result_q;
   assign bus.done          = done_q;
   assign bus.div_use       = busy_q;

   always_comb begin
      start_signed = (bus.div_opcode == DIV) || (bus.div_opcode == REM);
      start_zero   = (bus.operand2 == 32'd0);
      start_ovf    = start_signed && (bus.operand1 == 32'h8000_0000) &&
                     (bus.operand2 == 32'hFFFF_FFFF);
      state_next   = state;
      case (state)
         IDLE:    if (bus.startE) state_next = (start_zero || start_ovf) ? FIX : CALC;
         CALC:    if (counter == 5'd31) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Special cases arrive with final values preloaded, so they bypass sign correction.
   always_comb begin
      rem_shift  = {rem, dividend[31]};
      diff       = rem_shift - {1'b0, divisor};
      op_signed  = (op == DIV) || (op == REM);
      quot_fix   = (op_signed && (sign_a ^ sign_b) && !special) ? -quot : quot;
      rem_fix    = (op_signed && sign_a && !special) ? -rem : rem;
      result_fix = quot_fix;
      case (op)
         DIV, DIVU: result_fix = quot_fix;
         REM, REMU: result_fix = rem_fix;
         default:   result_fix = quot_fix;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         op       <= 2'b00;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         special  <= 1'b0;
         dividend <= 32'd0;
         divisor  <= 32'd0;
         quot     <= 32'd0;
         rem      <= 32'd0;
         counter  <= 5'd0;
         result_q <= 32'd0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.startE) begin
                  op       <= bus.div_opcode;
                  sign_a   <= start_signed & bus.operand1[31];
                  sign_b   <= start_signed & bus.operand2[31];
                  dividend <= (start_signed && bus.operand1[31]) ? -bus.operand1 : bus.operand1;
                  divisor  <= (start_signed && bus.operand2[31]) ? -bus.operand2 : bus.operand2;
                  counter  <= 5'd0;
                  busy_q   <= 1'b1;
                  result_q <= 32'd0;
                  if (start_zero) begin
                     quot    <= 32'hFFFF_FFFF;
                     rem     <= bus.operand1;
                     special <= 1'b1;
                  end else if (start_ovf) begin
                     quot    <= 32'h8000_0000;
                     rem     <= 32'd0;
                     special <= 1'b1;
                  end else begin
                     quot    <= 32'd0;
                     rem     <= 32'd0;
                     special <= 1'b0;
                  end
               end
            end
            CALC: begin
               dividend <= {dividend[30:0], 1'b0};
               counter  <= counter + 5'd1;
               if (!diff[32]) begin
                  rem  <= diff[31:0];
                  quot <= {quot[30:0], 1'b1};
               end else begin
                  rem  <= rem_shift[31:0];
                  quot <= {quot[30:0], 1'b0};
               end
            end
            FIX: begin
               result_q <= result_fix;
               done_q   <= 1'b1;
               busy_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/divider_iterative.md
# divider_iterative

Iterative radix-2 restoring divider for the RV32M division instructions (DIV, DIVU, REM, REMU). It sits in the execute stage next to the iterative multiplier. It accepts one operation per start pulse and produces a 32-bit quotient or remainder after a fixed number of cycles. It drives a busy/stall flag for the hazard unit while computing.

## Interface
- DIV, default 2'b00, signed quotient opcode
- DIVU, default 2'b01, unsigned quotient opcode
- REM, default 2'b10, signed remainder opcode
- REMU, default 2'b11, unsigned remainder opcode
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset (rst=0 at a rising edge resets)
- startE  in  1  start request from execute stage; sampled each rising edge
- div_opcode  in  2  operation select, sampled with startE
- operand1  in  32  dividend (rs1), sampled with startE
- operand2  in  32  divisor (rs2), sampled with startE
- result_divide  out  32  quotient or remainder
- done  out  1  one-cycle pulse: result_divide valid
- div_use  out  1  busy; pipeline stalls while high

## Operation
- Reset values:
  - result_divide=0, done=0, div_use=0.
  - Internal state is IDLE, counter=0, and all working registers are 0.
- States: IDLE, CALC, FIX.
- IDLE:
  - On startE=1, latch the opcode, the operand signs, |operand1| and |operand2| (signed opcodes) or the raw operands (unsigned).
  - Then set quotient=0, partial remainder=0, counter=0, div_use=1, result_divide=0.
  - Next state is CALC, unless a special case applies.
- Special cases, detected in IDLE on start. These skip CALC and go directly to FIX with the final value preloaded:
  - Divide by zero (operand2=0): quotient=32'hFFFFFFFF for both DIV and DIVU; remainder=operand1.
  - Signed overflow (DIV/REM, operand1=32'h80000000, operand2=32'hFFFFFFFF): quotient=32'h80000000, remainder=0.
- CALC, one iteration per cycle, counter 0..31:
  - Shift the remainder left by 1, bringing in the next dividend MSB.
  - Trial-subtract the divisor using a 33-bit subtract.
  - If the result is non-negative, keep the difference and set quotient bit=1; otherwise restore and set bit=0.
  - After the counter=31 iteration, go to FIX.
- FIX:
  - Apply sign correction, signed opcodes only:
    - The quotient is negated if the operand signs differ.
    - The remainder takes the sign of the dividend.
  - Load result_divide with the quotient (DIV/DIVU) or remainder (REM/REMU).
  - Set done=1 and div_use=0, then go to IDLE.
- Output holding:
  - result_divide holds its value until the next accepted start, which clears it to 0.
  - done is high for exactly one cycle.
- Event priorities:
  - startE while in CALC or FIX is ignored; the operation in flight is not disturbed.
  - startE in the same cycle done is high (state is IDLE the next edge) is accepted normally on the following edge.
  - rst=0 in any state, including mid-CALC, aborts the operation and returns all outputs to their reset values at that edge. No done is produced for the aborted operation.

## Timing
- Edge 0 is the rising edge at which startE=1 is sampled in IDLE.
- Normal operation:
  - div_use=1 after edge 0.
  - CALC occupies edges 1..32; FIX occurs at edge 33.
  - After edge 33: done=1, div_use=0, result valid.
  - After edge 34: done=0.
  - Latency is 33 cycles, start to done.
- Special cases:
  - FIX at edge 1; done=1 and result valid after edge 1, div_use=0.
  - Latency is 1 cycle.
- Throughput:
  - One operation per 34 cycles back-to-back, normal case.
  - One operation per 2 cycles back-to-back, special case.
- div_use is registered; it is never combinationally derived from startE.

## Test plan
- DIV 100 / 7:
  - done after exactly 33 cycles with result_divide=14.
  - REM on the same operands gives 2.
  - div_use high for cycles 1..33.
- Signed sign rules:
  - DIV -7 / 2 → 32'hFFFFFFFD (-3).
  - REM -7 / 2 → 32'hFFFFFFFF (-1).
  - REM 7 / -2 → 1.
- Unsigned full range:
  - DIVU 32'hFFFFFFFF / 1 → 32'hFFFFFFFF.
  - REMU 32'hFFFFFFFF / 32'h10 → 32'hF.
- Special cases, each with done after 1 cycle:
  - DIV 5 / 0 → 32'hFFFFFFFF.
  - REMU 5 / 0 → 5.
  - DIV 32'h80000000 / -1 → 32'h80000000.
  - REM 32'h80000000 / -1 → 0.
- startE pulsed again at cycle 10 of an operation with different operands:
  - Ignored; the original result and done timing are unchanged.
- rst=0 at cycle 15 of DIVU:
  - All outputs 0 the next cycle; no done pulse.
  - A new start afterwards completes correctly in 33 cycles.
